// File: rtl/score_display_pkg.sv
// Shared constants and types for the score display scanner.
//   - Active-high segment patterns {g,f,e,d,c,b,a} for digits, 'P', '-' and blank.
//   - Digit positions used by score mode and banner mode (bit 7 = leftmost).
//   - Snapshot record of the game-core inputs held for a whole frame.
package score_display_pkg;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_P     = 7'b1110011;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [2:0] DIG_LEFT      = 3'd7;
  localparam logic [2:0] DIG_RIGHT     = 3'd0;
  localparam logic [2:0] DIG_BANNER_HI = 3'd4;
  localparam logic [2:0] DIG_BANNER_LO = 3'd3;

  typedef struct packed {
    logic [3:0] left;
    logic [3:0] right;
    logic       game_over;
    logic       winner;
  } score_snap_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit value to seven-segment pattern (active-high, {g,f,e,d,c,b,a}).
//   value_i : binary value; 0..9 show the digit, 10..15 show '-'
//   seg_o   : active-high segment pattern
module seg7_decode
  import score_display_pkg::*;
(
  input  logic [3:0] value_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (value_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/score_display_scan.sv
// Time-multiplexed 8-digit common-anode seven-segment driver for the tennis score.
// Inputs are snapshotted once per frame so a frame never mixes two input states.
//   clk, reset_n            : clock, asynchronous active-low reset
//   score_left/score_right  : win counts (0..9; 10..15 display '-')
//   game_over, winner       : banner request and winning player (0 = P1, 1 = P2)
//   an                      : anodes, active-low, bit 7 = leftmost digit
//   seg                     : segments {g,f,e,d,c,b,a}, active-low
//   frame_tick              : one-cycle pulse on the last cycle of each frame
// Build option: define SCORE_DISPLAY_BLINK_EN to blink the winner banner every
// BLINK_FRAMES frames; otherwise the banner is steady and no blink logic exists.
module score_display_scan
  import score_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] score_left,
  input  logic [3:0] score_right,
  input  logic       game_over,
  input  logic       winner,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       frame_tick
);

  localparam int unsigned CntW = $clog2(REFRESH_DIV);
  localparam logic [CntW-1:0] CntLast = CntW'(REFRESH_DIV - 1);

  logic [CntW-1:0] refresh_cnt_q, refresh_cnt_d;
  logic [2:0]      digit_idx_q, digit_idx_d;
  score_snap_t     snap_q, snap_d;
  logic [7:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            frame_tick_q, frame_tick_d;

  logic            cnt_last;
  logic            frame_end;
  logic            banner_dark;
  logic            digit_on;
  logic            use_p;
  logic [3:0]      digit_val;
  logic [6:0]      dec_seg;

  always_comb begin
    cnt_last      = (refresh_cnt_q == CntLast);
    frame_end     = cnt_last && (digit_idx_q == 3'd7);
    refresh_cnt_d = cnt_last ? '0 : refresh_cnt_q + CntW'(1);
    digit_idx_d   = cnt_last ? digit_idx_q + 3'd1 : digit_idx_q;
    snap_d        = frame_end ? '{left: score_left, right: score_right,
                                  game_over: game_over, winner: winner} : snap_q;
    // Registered from next state so the pulse lands on the frame's last cycle.
    frame_tick_d  = (refresh_cnt_d == CntLast) && (digit_idx_d == 3'd7);
  end

`ifdef SCORE_DISPLAY_BLINK_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [7:0] frame_cnt_inc;
  logic       dark_q, dark_d;

  always_comb begin
    frame_cnt_d   = frame_cnt_q;
    dark_d        = dark_q;
    frame_cnt_inc = frame_cnt_q + 8'd1;
    if (frame_end && snap_d.game_over) begin
      if (!snap_q.game_over) begin
        // Entering banner mode always starts on a visible phase.
        frame_cnt_d = 8'd0;
        dark_d      = 1'b0;
      end else if (frame_cnt_inc == 8'(BLINK_FRAMES)) begin
        frame_cnt_d = 8'd0;
        dark_d      = ~dark_q;
      end else begin
        frame_cnt_d = frame_cnt_inc;
      end
    end
    banner_dark = dark_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q <= 8'd0;
      dark_q      <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      dark_q      <= dark_d;
    end
  end
`else
  always_comb banner_dark = 1'b0;
`endif

  // Digit content for the slot being entered, using next-state index and shadows.
  always_comb begin
    digit_on  = 1'b0;
    use_p     = 1'b0;
    digit_val = 4'd0;
    if (snap_d.game_over) begin
      case (digit_idx_d)
        DIG_BANNER_HI: begin
          digit_on = 1'b1;
          use_p    = 1'b1;
        end
        DIG_BANNER_LO: begin
          digit_on  = 1'b1;
          digit_val = snap_d.winner ? 4'd2 : 4'd1;
        end
        default: ;
      endcase
      if (banner_dark) digit_on = 1'b0;
    end else begin
      case (digit_idx_d)
        DIG_LEFT: begin
          digit_on  = 1'b1;
          digit_val = snap_d.left;
        end
        DIG_RIGHT: begin
          digit_on  = 1'b1;
          digit_val = snap_d.right;
        end
        default: ;
      endcase
    end
  end

  seg7_decode u_seg7_decode (
    .value_i (digit_val),
    .seg_o   (dec_seg)
  );

  always_comb begin
    an_d  = digit_on ? ~(8'd1 << digit_idx_d) : 8'hFF;
    seg_d = digit_on ? ~(use_p ? SEG_P : dec_seg) : ~SEG_BLANK;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      refresh_cnt_q <= '0;
      digit_idx_q   <= 3'd0;
      snap_q        <= '0;
      an_q          <= 8'hFF;
      seg_q         <= 7'h7F;
      frame_tick_q  <= 1'b0;
    end else begin
      refresh_cnt_q <= refresh_cnt_d;
      digit_idx_q   <= digit_idx_d;
      snap_q        <= snap_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      frame_tick_q  <= frame_tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_score_display_scan.sv
// Scoreboard bench for score_display_scan: a timeline model predicts every output
// cycle from elapsed time since reset and the inputs present at each frame boundary.
module tb_score_display_scan;

  localparam int unsigned DIV   = 4;
  localparam int unsigned BF    = 2;
  localparam int unsigned FRAME = 8 * DIV;

  logic       clk;
  logic       reset_n;
  logic [3:0] score_left;
  logic [3:0] score_right;
  logic       game_over;
  logic       winner;
  logic [7:0] an;
  logic [6:0] seg;
  logic       frame_tick;

  score_display_scan #(
    .REFRESH_DIV  (DIV),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .score_left  (score_left),
    .score_right (score_right),
    .game_over   (game_over),
    .winner      (winner),
    .an          (an),
    .seg         (seg),
    .frame_tick  (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         t;
    logic [7:0] an;
    logic [6:0] seg;
    logic       tick;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model state: cycles since reset, and what the display is currently showing.
  int         t = 0;
  logic [3:0] m_left = 4'd0;
  logic [3:0] m_right = 4'd0;
  logic       m_go = 1'b0;
  logic       m_win = 1'b0;
  int         m_banner_frames = 0;

  function automatic logic [6:0] glyph(input int v);
    case (v)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111101;
      7: return 7'b0000111;
      8: return 7'b1111111;
      9: return 7'b1101111;
      default: return 7'b1000000;
    endcase
  endfunction

  function automatic exp_t predict(input int tt);
    exp_t       e;
    int         idx;
    bit         on;
    bit         dark;
    logic [6:0] pat;
    idx  = (tt / DIV) % 8;
    on   = 1'b0;
    pat  = 7'd0;
    dark = 1'b0;
`ifdef SCORE_DISPLAY_BLINK_EN
    dark = ((m_banner_frames / BF) % 2) == 1;
`endif
    if (m_go) begin
      if (!dark && idx == 4) begin on = 1'b1; pat = 7'b1110011; end
      if (!dark && idx == 3) begin on = 1'b1; pat = glyph(m_win ? 2 : 1); end
    end else begin
      if (idx == 7) begin on = 1'b1; pat = glyph(int'(m_left)); end
      if (idx == 0) begin on = 1'b1; pat = glyph(int'(m_right)); end
    end
    e.t    = tt;
    e.an   = on ? ~(8'd1 << idx) : 8'hFF;
    e.seg  = on ? ~pat : 7'h7F;
    e.tick = (tt % FRAME) == FRAME - 1;
    return e;
  endfunction

  // Model: advance time, latch inputs at each frame boundary, queue the expectation.
  always @(posedge clk) begin
    if (!reset_n) begin
      t = 0;
      m_left = 4'd0; m_right = 4'd0; m_go = 1'b0; m_win = 1'b0;
      m_banner_frames = 0;
      exp_q.delete();
    end else begin
      t++;
      if (t % FRAME == 0) begin
        if (game_over) m_banner_frames = m_go ? m_banner_frames + 1 : 0;
        m_left  = score_left;
        m_right = score_right;
        m_go    = game_over;
        m_win   = winner;
      end
      exp_q.push_back(predict(t));
    end
  end

  // Monitor: every cycle out of reset the DUT presents a digit slot; compare it.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (an !== e.an) begin
        errors++;
        $display("FAIL an t=%0d got %h expected %h", e.t, an, e.an);
      end
      checks++;
      if (seg !== e.seg) begin
        errors++;
        $display("FAIL seg t=%0d got %b expected %b", e.t, seg, e.seg);
      end
      checks++;
      if (frame_tick !== e.tick) begin
        errors++;
        $display("FAIL frame_tick t=%0d got %b expected %b", e.t, frame_tick, e.tick);
      end
    end
  end

  task automatic check_reset_outputs(input string name);
    checks++;
    if (an !== 8'hFF) begin
      errors++;
      $display("FAIL %s an got %h expected ff", name, an);
    end
    checks++;
    if (seg !== 7'h7F) begin
      errors++;
      $display("FAIL %s seg got %h expected 7f", name, seg);
    end
    checks++;
    if (frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL %s frame_tick got %b expected 0", name, frame_tick);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Step to the negedge where the current frame position equals ph (bounded).
  task automatic go_to_phase(input int ph);
    for (int i = 0; i < int'(FRAME) + 1; i++) begin
      if (t % FRAME == ph) return;
      @(negedge clk);
    end
    errors++;
    $display("FAIL go_to_phase got %0d expected %0d", t % FRAME, ph);
  endtask

  initial begin
    reset_n     = 1'b0;
    score_left  = 4'd2;
    score_right = 4'd5;
    game_over   = 1'b0;
    winner      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    @(negedge clk);
    reset_n = 1'b1;

    run(2 * FRAME);
    go_to_phase(10);
    score_right = 4'd6;
    run(2 * FRAME);
    score_left = 4'd12;
    run(2 * FRAME);
    game_over = 1'b1;
    winner    = 1'b1;
    run(5 * FRAME);
    game_over = 1'b0;
    winner    = 1'b0;
    run(FRAME);
    // Short banner request that is gone before the frame boundary.
    go_to_phase(5);
    game_over = 1'b1;
    run(5);
    game_over = 1'b0;
    run(2 * FRAME);

    go_to_phase(13);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    run(2 * FRAME);

    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 6) == 0) begin
        score_left  = 4'($urandom_range(0, 15));
        score_right = 4'($urandom_range(0, 15));
        game_over   = ($urandom_range(0, 3) == 0);
        winner      = 1'($urandom_range(0, 1));
      end
    end
    run(3);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/score_display_scan.md
# score_display_scan

Time-multiplexed 8-digit seven-segment driver that sits directly downstream of the tennis game core. It consumes the left/right win counts and the game-over/winner status, and drives the board's common-anode display. It owns the refresh timing, frame-aligned snapshotting of its inputs (no tearing mid-scan) and the optional blinking winner banner.

## Interface
- REFRESH_DIV, 100000: clk cycles each digit is enabled; legal range 2..2^20.
- BLINK_FRAMES, 64: full 8-digit frames per blink half-period; legal range 1..255.
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- score_left  in  4  left player wins, binary 0..9
- score_right  in  4  right player wins, binary 0..9
- game_over  in  1  1 = match decided, show winner banner
- winner  in  1  0 = player 1 (left), 1 = player 2 (right); valid when game_over=1
- an  out  8  digit anodes, active-low, bit 7 = leftmost digit
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- frame_tick  out  1  one-cycle pulse on the last cycle of each frame

## Operation
- Counters:
  - refresh_cnt counts 0..REFRESH_DIV-1.
  - At terminal count, digit_idx increments modulo 8.
  - A frame is digit_idx 0..7 in full.
- Snapshot:
  - score_left, score_right, game_over and winner are registered into shadow registers only when refresh_cnt is terminal and digit_idx=7 (frame end).
  - The display always uses shadows, so a frame never mixes two input states.
- Score mode (shadow game_over=0):
  - Digit 7 shows the left score and digit 0 shows the right score.
  - Digits 1..6 have their anode deasserted but still consume their scan slot, so duty cycle is constant at 1/8.
- Banner mode (shadow game_over=1):
  - Digit 4 shows 'P' (gfedcba=1110011).
  - Digit 3 shows '1' when winner=0, '2' when winner=1.
  - All other digits are blank.
- Decode (gfedcba, active-high before inversion):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - Values 10..15 show '-' (1000000).
- Blanked digits: an bit=1, seg=7'h7F.

## Timing
- Reset values: an=8'hFF, seg=7'h7F, frame_tick=0, refresh_cnt=0, digit_idx=0, shadows=0, blink phase=visible, frame counter=0.
- an/seg are registered. They reflect the new digit_idx one cycle after the cycle in which refresh_cnt is terminal.
- The first digit (idx 0) is driven on the cycle after reset_n deasserts.
- frame_tick is combinational-free (registered), high for exactly 1 cycle every 8*REFRESH_DIV cycles, aligned with the shadow load.
- Input changes become visible at the start of the frame following the next frame_tick. Worst-case latency is 8*REFRESH_DIV+1 cycles.
- reset_n asserted mid-frame: all outputs go to reset values immediately (asynchronously). Scanning restarts at idx 0.
- game_over toggling within a frame is ignored until frame end. A pulse shorter than a frame that is not present at frame end is never displayed.

## Configuration
- SCORE_DISPLAY_BLINK_EN defined:
  - In banner mode, a frame counter counts frame_tick pulses.
  - The blink phase toggles every BLINK_FRAMES frames.
  - During the dark phase all anodes are 1.
  - The frame counter and phase reset to 0/visible on each entry into banner mode.
- Not defined: the banner is steady, and no frame counter or phase logic is synthesised.
- Score mode is identical either way.

## Structure
- score_display_pkg holds:
  - the 7-bit segment constants (digits 0..9, SEG_P, SEG_DASH, SEG_BLANK);
  - the digit position constants (DIG_LEFT=7, DIG_RIGHT=0, DIG_BANNER_HI=4, DIG_BANNER_LO=3).
- Sub-module seg7_decode: 4-bit value to 7-bit active-high pattern (combinational); instantiated once on the muxed digit value.

## Test plan
- Reset, REFRESH_DIV=4, score_left=2, score_right=5:
  - After first frame_tick (cycle 32), idx 7 slot gives an=8'h7F, seg=~1011011.
  - idx 0 slot gives an=8'hFE, seg=~1101101.
  - idx 1..6 give an=8'hFF.
- Change score_right 5->6 at cycle 10 of a frame -> remainder of the frame still shows 5; the next frame shows 6 (~1111101).
- score_left=12 -> digit 7 shows seg=~1000000 after the frame boundary.
- game_over=1, winner=1 -> next frame: idx4 an=8'hEF seg=~1110011, idx3 an=8'hF7 seg=~1011011.
- With SCORE_DISPLAY_BLINK_EN, BLINK_FRAMES=2: banner is visible for 2 frames, then an=8'hFF for 2 frames, repeating. Without the macro the banner is steady.
- reset_n pulsed low at cycle 13 mid-frame -> an=8'hFF, seg=7'h7F the same cycle. After release, idx restarts at 0 and frame_tick arrives 32 cycles later.
